sqrt_result_display: RTL and testbench

Downstream consumer of the square-root calculator's 8-bit result/valid pair. On each valid pulse it captures the result, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed, active-low 4-digit seven-segment display with leading-zero blanking. The BCD value is also exported with a one-cycle strobe for any further consumer.

---
 rtl/sqrt_result_display.sv | 186 ++++++++++++++++++
 tb/tb_sqrt_result_display.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_result_display.sv
// Purpose : turns 8-bit sqrt results into 3 BCD digits and scans them onto a 4-digit active-low 7-seg display.
// Latency : bcd/bcd_valid 9 cycles after valid is sampled; an/seg registered, 1 cycle behind the refresh counter.
// Backpressure: none; valid arriving while a conversion is iterating is dropped, busy flags that window.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   result, valid   8-bit unsigned value and its one-cycle strobe
//   busy            high while a conversion occupies the engine
//   bcd, bcd_valid  {hundreds, tens, units} of the last finished conversion, one-cycle update strobe
//   an, seg         active-low digit enables (an[0]=units) and segments {g,f,e,d,c,b,a}
module sqrt_result_display #(
    parameter int REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  result,
    input  logic        valid,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]  shift_q;
    logic [11:0] scratch_q;
    logic [11:0] scratch_adj;
    logic [2:0]  iter_q;
    logic        start;

    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              digit_sel;
    logic [3:0]              an_nxt;
    logic [6:0]              seg_nxt;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE also accepts a new valid: the result is being committed in that
    // very cycle, so a conversion launched here keeps the throughput at one
    // result every 9 cycles without disturbing the value being written out.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    start     = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (iter_q == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (valid) begin
                    start     = 1'b1;
                    state_nxt = CONVERT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Double-dabble datapath
    // ------------------------------------------------------------------
    function automatic logic [3:0] add3(input logic [3:0] nib);
        add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    assign scratch_adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= 8'd0;
            scratch_q <= 12'd0;
            iter_q    <= 3'd0;
            bcd       <= 12'd0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (start) begin
                shift_q   <= result;
                scratch_q <= 12'd0;
                iter_q    <= 3'd0;
            end else if (state == CONVERT) begin
                // Adjust then shift the 20-bit {scratch, shift} pair left by one.
                {scratch_q, shift_q} <= {scratch_adj[10:0], shift_q, 1'b0};
                iter_q               <= iter_q + 3'd1;
            end
            if (state == DONE) begin
                bcd       <= scratch_q;
                bcd_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_code(input logic [3:0] digit, input logic blank);
        if (blank) begin
            seg_code = 7'b1111111;
        end else begin
            case (digit)
                4'd0:    seg_code = 7'b1000000;
                4'd1:    seg_code = 7'b1111001;
                4'd2:    seg_code = 7'b0100100;
                4'd3:    seg_code = 7'b0110000;
                4'd4:    seg_code = 7'b0011001;
                4'd5:    seg_code = 7'b0010010;
                4'd6:    seg_code = 7'b0000010;
                4'd7:    seg_code = 7'b1111000;
                4'd8:    seg_code = 7'b0000000;
                4'd9:    seg_code = 7'b0010000;
                default: seg_code = 7'b1111111;
            endcase
        end
    endfunction

    assign digit_sel = refresh_q[REFRESH_BITS-1 -: 2];

    // Leading-zero blanking only affects seg; the digit enable stays asserted.
    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = 7'b1111111;
        case (digit_sel)
            2'd0: begin
                an_nxt  = 4'b1110;
                seg_nxt = seg_code(bcd[3:0], 1'b0);
            end
            2'd1: begin
                an_nxt  = 4'b1101;
                seg_nxt = seg_code(bcd[7:4], (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0));
            end
            2'd2: begin
                an_nxt  = 4'b1011;
                seg_nxt = seg_code(bcd[11:8], bcd[11:8] == 4'd0);
            end
            default: begin
                an_nxt  = 4'b1111;
                seg_nxt = 7'b1111111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            an        <= 4'b1111;
            seg       <= 7'b1111111;
        end else begin
            refresh_q <= refresh_q + REFRESH_ONE;
            an        <= an_nxt;
            seg       <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_sqrt_result_display.sv
module tb_sqrt_result_display;

    logic        clk;
    logic        reset;
    logic [7:0]  result;
    logic        valid;
    logic        busy;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [3:0]  an;
    logic [6:0]  seg;

    sqrt_result_display #(.REFRESH_BITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .result    (result),
        .valid     (valid),
        .busy      (busy),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge count; read at negedges, so it equals the number of edges seen.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every bcd_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bcd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bcd_valid", {20'd0, bcd}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bcd_value", {20'd0, bcd}, {20'd0, e.bcd});
                check("bcd_valid_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; the valid is sampled at the next posedge (edge N).
    // Returns at the negedge after edge N with n = N.
    task automatic send(input logic [7:0] r, input logic [11:0] exp_bcd, input bit push, output int n);
        exp_t e;
        result = r;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        n      = cyc;
        if (push) begin
            e.bcd = exp_bcd;
            e.cyc = n + 9;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Sample 16 cycles of the scan and check each slot's segments.
    task automatic disp_check(input string tag, input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
        int nu = 0, nt = 0, nh = 0, nx = 0;
        for (int i = 0; i < 16; i++) begin
            case (an)
                4'b1110: begin nu++; check({tag, "_seg_units"}, seg, u); end
                4'b1101: begin nt++; check({tag, "_seg_tens"}, seg, t); end
                4'b1011: begin nh++; check({tag, "_seg_hundreds"}, seg, h); end
                4'b1111: begin nx++; check({tag, "_seg_unused"}, seg, 7'b1111111); end
                default: check({tag, "_an_code"}, an, 4'b1110);
            endcase
            @(negedge clk);
        end
        check({tag, "_units_slots"}, nu, 4);
        check({tag, "_tens_slots"}, nt, 4);
        check({tag, "_hundreds_slots"}, nh, 4);
        check({tag, "_unused_slots"}, nx, 4);
    endtask

    initial begin
        int n;
        int n2;
        reset  = 1'b1;
        valid  = 1'b1;   // must be ignored while reset is asserted
        result = 8'd42;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_bcd", bcd, 12'h000);
        check("rst_bcd_valid", bcd_valid, 1'b0);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'b1111111);
        reset = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check("first_an_after_reset", an, 4'b1110);
        check("busy_after_reset_valid", busy, 1'b0);
        idle(2);

        // 15: busy window and latency
        send(8'd15, 12'h015, 1'b1, n);
        for (int k = 0; k < 9; k++) begin
            check("busy_high_window", busy, 1'b1);
            @(negedge clk);
        end
        check("busy_fall", busy, 1'b0);
        idle(3);

        send(8'd255, 12'h255, 1'b1, n);
        idle(12);

        send(8'd0, 12'h000, 1'b1, n);
        idle(11);
        check("bcd_zero_held", bcd, 12'h000);
        disp_check("zero", 7'b1000000, 7'b1111111, 7'b1111111);

        // 7, with a 99 pulse at edge N+4 that must be dropped,
        // then 99 accepted at edge N+9.
        send(8'd7, 12'h007, 1'b1, n);
        while (cyc < n + 3) @(negedge clk);
        result = 8'd99;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        while (cyc < n + 8) @(negedge clk);
        send(8'd99, 12'h099, 1'b1, n2);
        check("back_to_back_busy", busy, 1'b1);
        idle(12);
        check("bcd_after_99", bcd, 12'h099);

        // 200 aborted by reset at edge N+5
        send(8'd200, 12'h200, 1'b0, n);
        while (cyc < n + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_bcd", bcd, 12'h000);
        check("abort_an", an, 4'b1111);
        check("abort_seg", seg, 7'b1111111);
        reset = 1'b0;
        idle(14);
        check("abort_bcd_stays", bcd, 12'h000);

        send(8'd105, 12'h105, 1'b1, n);
        idle(11);
        disp_check("v105", 7'b0010010, 7'b1000000, 7'b1111001);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
